// File: rtl/sram_sp_be_ctrl_pkg.sv
// Shared types for the single-port bit-enable SRAM controller.
// Used by sram_sp_be_ctrl, sram_sp_be_ctrl_arb and sram_sp_be_ctrl_if.
package sram_sp_be_ctrl_pkg;

   // Controller FSM: clear the array, then arbitrate forever
   typedef enum logic {
      StInit = 1'b0,
      StArb  = 1'b1
   } state_e;

   // Requester identity, also used as the read-response owner tag
   typedef enum logic {
      PortA = 1'b0,
      PortB = 1'b1
   } port_e;

endpackage

// File: rtl/sram_sp_be_ctrl_if.sv
// Bus bundle for sram_sp_be_ctrl: two requester ports, the SRAM macro side
// and the init-done flag. 'slave' is the controller view, 'master' is the
// requester/macro view.
interface sram_sp_be_ctrl_if #(
   parameter int unsigned SIZE     = 256,
   parameter int unsigned SIZE_COL = 8,
   parameter int unsigned DATA_WD  = 32
);
   localparam int unsigned SIZE_WD = $clog2(SIZE);
   localparam int unsigned MSK_WD  = DATA_WD / SIZE_COL;

   logic               init_done_o;

   logic               a_req_val_i;
   logic               a_req_rdy_o;
   logic               a_req_wr_i;
   logic [SIZE_WD-1:0] a_req_adr_i;
   logic [MSK_WD-1:0]  a_req_msk_i;
   logic [DATA_WD-1:0] a_req_dat_i;
   logic               a_rsp_val_o;
   logic [DATA_WD-1:0] a_rsp_dat_o;

   logic               b_req_val_i;
   logic               b_req_rdy_o;
   logic               b_req_wr_i;
   logic [SIZE_WD-1:0] b_req_adr_i;
   logic [MSK_WD-1:0]  b_req_msk_i;
   logic [DATA_WD-1:0] b_req_dat_i;
   logic               b_rsp_val_o;
   logic [DATA_WD-1:0] b_rsp_dat_o;

   logic [SIZE_WD-1:0] sram_adr_o;
   logic [MSK_WD-1:0]  sram_wr_val_o;
   logic [DATA_WD-1:0] sram_wr_dat_o;
   logic               sram_rd_val_o;
   logic [DATA_WD-1:0] sram_rd_dat_i;

   modport slave (
      output init_done_o,
      input  a_req_val_i, a_req_wr_i, a_req_adr_i, a_req_msk_i, a_req_dat_i,
      output a_req_rdy_o, a_rsp_val_o, a_rsp_dat_o,
      input  b_req_val_i, b_req_wr_i, b_req_adr_i, b_req_msk_i, b_req_dat_i,
      output b_req_rdy_o, b_rsp_val_o, b_rsp_dat_o,
      output sram_adr_o, sram_wr_val_o, sram_wr_dat_o, sram_rd_val_o,
      input  sram_rd_dat_i
   );

   modport master (
      input  init_done_o,
      output a_req_val_i, a_req_wr_i, a_req_adr_i, a_req_msk_i, a_req_dat_i,
      input  a_req_rdy_o, a_rsp_val_o, a_rsp_dat_o,
      output b_req_val_i, b_req_wr_i, b_req_adr_i, b_req_msk_i, b_req_dat_i,
      input  b_req_rdy_o, b_rsp_val_o, b_rsp_dat_o,
      input  sram_adr_o, sram_wr_val_o, sram_wr_dat_o, sram_rd_val_o,
      output sram_rd_dat_i
   );

endinterface

// File: rtl/sram_sp_be_ctrl_arb.sv
// Two-way grant logic for sram_sp_be_ctrl.
// SRAM_SP_BE_CTRL_RR_EN defined: round-robin on contention (pointer of last
// winner, reset to B so A wins first). Undefined: fixed priority, A wins.
module sram_sp_be_ctrl_arb
   import sram_sp_be_ctrl_pkg::*;
(
`ifdef SRAM_SP_BE_CTRL_RR_EN
   input  logic  clk,
   input  logic  rst_n,
`endif
   input  logic  en_i,
   input  logic  a_val_i,
   input  logic  b_val_i,
   output logic  gnt_val_o,
   output port_e gnt_port_o
);

   assign gnt_val_o = en_i & (a_val_i | b_val_i);

`ifdef SRAM_SP_BE_CTRL_RR_EN
   port_e last_q;

   // Pick the requester; on contention favour the one not granted last
   always_comb begin
      gnt_port_o = PortA;
      if (a_val_i && b_val_i) begin
         gnt_port_o = (last_q == PortA) ? PortB : PortA;
      end else if (b_val_i) begin
         gnt_port_o = PortB;
      end
   end

   // Remember the last winner on every transfer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= PortB;
      end else if (gnt_val_o) begin
         last_q <= gnt_port_o;
      end
   end
`else
   // Fixed priority: A wins whenever it is valid
   always_comb begin
      gnt_port_o = (!a_val_i && b_val_i) ? PortB : PortA;
   end
`endif

endmodule

// File: rtl/sram_sp_be_ctrl.sv
// Two-requester controller for a single-port bit-enable SRAM macro.
// Clears the array after reset, then grants one access per cycle and routes
// the 1-cycle-latency read data back to the issuing port.
// Optional macro SRAM_SP_BE_CTRL_RR_EN selects round-robin arbitration
// (default: fixed priority, port A first).
module sram_sp_be_ctrl
   import sram_sp_be_ctrl_pkg::*;
#(
   parameter int unsigned SIZE     = 256,
   parameter int unsigned SIZE_COL = 8,
   parameter int unsigned DATA_WD  = 32
) (
   input logic            clk,
   input logic            rst_n,
   sram_sp_be_ctrl_if.slave bus
);

   localparam int unsigned SIZE_WD = $clog2(SIZE);
   localparam int unsigned MSK_WD  = DATA_WD / SIZE_COL;
   localparam logic [SIZE_WD-1:0] LastAdr = SIZE_WD'(SIZE - 1);

   state_e             state_q, state_d;
   logic [SIZE_WD-1:0] cnt_q, cnt_d;

   logic               gnt_val;
   port_e              gnt_port;

   logic               sel_wr;
   logic [SIZE_WD-1:0] sel_adr;
   logic [MSK_WD-1:0]  sel_msk;
   logic [DATA_WD-1:0] sel_dat;

   logic               a_rdy, b_rdy;
   logic [SIZE_WD-1:0] sram_adr;
   logic [MSK_WD-1:0]  sram_wr_val;
   logic [DATA_WD-1:0] sram_wr_dat;
   logic               sram_rd_val;

   logic               rsp_val_q, rsp_val_d;
   port_e              rsp_own_q, rsp_own_d;
   logic               a_rsp_val, b_rsp_val;
   logic [DATA_WD-1:0] a_hold_q, b_hold_q;

   sram_sp_be_ctrl_arb u_arb (
`ifdef SRAM_SP_BE_CTRL_RR_EN
      .clk        (clk),
      .rst_n      (rst_n),
`endif
      .en_i       (state_q == StArb),
      .a_val_i    (bus.a_req_val_i),
      .b_val_i    (bus.b_req_val_i),
      .gnt_val_o  (gnt_val),
      .gnt_port_o (gnt_port)
   );

   // Route the granted port's request fields
   always_comb begin
      sel_wr  = bus.a_req_wr_i;
      sel_adr = bus.a_req_adr_i;
      sel_msk = bus.a_req_msk_i;
      sel_dat = bus.a_req_dat_i;
      if (gnt_port == PortB) begin
         sel_wr  = bus.b_req_wr_i;
         sel_adr = bus.b_req_adr_i;
         sel_msk = bus.b_req_msk_i;
         sel_dat = bus.b_req_dat_i;
      end
   end

   // FSM next state, clear sweep and SRAM command generation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sram_adr    = '0;
      sram_wr_val = '0;
      sram_wr_dat = '0;
      sram_rd_val = 1'b0;
      a_rdy       = 1'b0;
      b_rdy       = 1'b0;
      rsp_val_d   = 1'b0;
      rsp_own_d   = rsp_own_q;
      unique case (state_q)
         StInit: begin
            sram_adr    = cnt_q;
            sram_wr_val = '1;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == LastAdr) begin
               state_d = StArb;
            end
         end
         StArb: begin
            if (gnt_val) begin
               a_rdy    = (gnt_port == PortA);
               b_rdy    = (gnt_port == PortB);
               sram_adr = sel_adr;
               if (sel_wr) begin
                  sram_wr_val = sel_msk;
                  sram_wr_dat = sel_dat;
               end else begin
                  sram_rd_val = 1'b1;
                  rsp_val_d   = 1'b1;
                  rsp_own_d   = gnt_port;
               end
            end
         end
         default: ;
      endcase
   end

   // State, clear counter and read-response tag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StInit;
         cnt_q     <= '0;
         rsp_val_q <= 1'b0;
         rsp_own_q <= PortA;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rsp_val_q <= rsp_val_d;
         rsp_own_q <= rsp_own_d;
      end
   end

   assign a_rsp_val = rsp_val_q && (rsp_own_q == PortA);
   assign b_rsp_val = rsp_val_q && (rsp_own_q == PortB);

   // Keep the last delivered word so rsp_dat never shows macro garbage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_hold_q <= '0;
         b_hold_q <= '0;
      end else begin
         if (a_rsp_val) a_hold_q <= bus.sram_rd_dat_i;
         if (b_rsp_val) b_hold_q <= bus.sram_rd_dat_i;
      end
   end

   assign bus.init_done_o   = (state_q == StArb);
   assign bus.a_req_rdy_o   = a_rdy;
   assign bus.b_req_rdy_o   = b_rdy;
   assign bus.a_rsp_val_o   = a_rsp_val;
   assign bus.b_rsp_val_o   = b_rsp_val;
   assign bus.a_rsp_dat_o   = a_rsp_val ? bus.sram_rd_dat_i : a_hold_q;
   assign bus.b_rsp_dat_o   = b_rsp_val ? bus.sram_rd_dat_i : b_hold_q;
   assign bus.sram_adr_o    = sram_adr;
   assign bus.sram_wr_val_o = sram_wr_val;
   assign bus.sram_wr_dat_o = sram_wr_dat;
   assign bus.sram_rd_val_o = sram_rd_val;

endmodule
